// File: rtl/spi_receiver.sv
// SPI peripheral-side deserializer: oversamples spi_clk/chip_select/serial_in on clock and rebuilds WIDTH-bit words.
// Optional macro SPI_RX_LSB_FIRST_EN selects LSB-first assembly (default MSB-first).
module spi_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             spi_clk,
  input  logic             chip_select,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done_process,
  output logic             frame_error,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_sclk_sync, r_cs_sync, r_sin_sync;
  logic             r_sclk_d;
  logic [CW-1:0]    r_bit_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             w_sclk_s, w_cs_s, w_sin_s, w_rise;

  // All three inputs use identical chains so data stays aligned with the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_sin_sync  <= 2'b00;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], spi_clk};
      r_cs_sync   <= {r_cs_sync[0], chip_select};
      r_sin_sync  <= {r_sin_sync[0], serial_in};
      r_sclk_d    <= r_sclk_sync[1];
    end
  end

  assign w_sclk_s = r_sclk_sync[1];
  assign w_cs_s   = r_cs_sync[1];
  assign w_sin_s  = r_sin_sync[1];
  assign w_rise   = w_sclk_s & ~r_sclk_d;

`ifdef SPI_RX_LSB_FIRST_EN
  assign w_shifted = {w_sin_s, r_shift[WIDTH-1:1]};
`else
  assign w_shifted = {r_shift[WIDTH-2:0], w_sin_s};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cs_s) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        // Chip-select release takes priority over a coincident edge.
        if (w_cs_s) begin
          w_state_nxt = IDLE;
          w_err_nxt   = (r_bit_cnt != '0);
          w_cnt_nxt   = '0;
        end else if (w_rise) begin
          w_shift_nxt = w_shifted;
          if (r_bit_cnt == LAST) begin
            w_data_nxt = w_shifted;
            w_done_nxt = 1'b1;
            w_cnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign data_out     = r_data;
  assign done_process = r_done;
  assign frame_error  = r_err;
  assign busy         = (r_state == SHIFT);
endmodule

// File: tb/tb_spi_receiver.sv
// Bench for spi_receiver: table of frames plus reset/stray-clock sequences; completed words are scoreboarded.
module tb_spi_receiver;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       spi_clk = 1'b0;
  logic       chip_select = 1'b1;
  logic       serial_in = 1'b0;
  logic [7:0] data_out;
  logic       done_process, frame_error, busy;

  spi_receiver #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .spi_clk(spi_clk), .chip_select(chip_select),
    .serial_in(serial_in), .data_out(data_out), .done_process(done_process),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_rise = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          exp_done;
    int          exp_err;
    logic [7:0]  exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] w);
    logic [7:0] r;
`ifdef SPI_RX_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard side: pop an expected word on every completion pulse.
  always @(negedge clock) begin
    if (reset) begin
      if (done_process || frame_error)
        chk("done_err_exclusive", {31'b0, done_process & frame_error}, 32'd0);
      if (frame_error) err_cnt++;
      if (done_process) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("word", {24'b0, data_out}, {24'b0, e});
        end
        chk("latency", cyc - t_rise, 32'd3);
      end
    end
  end

  task automatic send_bits(input logic [15:0] bits, input int n);
    logic [7:0] w = '0;
    int k = 0;
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clock);
      serial_in = bits[i];
      w = {w[6:0], bits[i]};
      k++;
      if (k == 8) begin
        exp_q.push_back(model(w));
        k = 0;
      end
      repeat (3) @(negedge clock);
      spi_clk = 1'b1;
      t_rise = cyc;
      repeat (4) @(negedge clock);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clock);
    chip_select = 1'b0;
    repeat (4) @(negedge clock);
    chk("busy_in_frame", {31'b0, busy}, 32'd1);
  endtask

  task automatic cs_high();
    @(negedge clock);
    chip_select = 1'b1;
    repeat (6) @(negedge clock);
    chk("busy_after_frame", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int d0, e0;
    tbl[0] = '{16'h00A5, 8,  1, 0, 8'hA5};
    tbl[1] = '{16'h3CC3, 16, 2, 0, 8'hC3};
    tbl[2] = '{16'h001F, 5,  0, 1, 8'hC3};
    tbl[3] = '{16'h0081, 8,  1, 0, 8'h81};
    tbl[4] = '{16'h0080, 8,  1, 0, 8'h80};
    tbl[5] = '{16'h0000, 8,  1, 0, 8'h00};
    tbl[6] = '{16'h07FD, 11, 1, 1, 8'hFF};

    // Reset held with toggling inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      spi_clk = ~spi_clk;
      serial_in = ~serial_in;
      chip_select = ~chip_select;
    end
    #1;
    chk("rst_data", {24'b0, data_out}, 32'd0);
    chk("rst_done", {31'b0, done_process}, 32'd0);
    chk("rst_err", {31'b0, frame_error}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    chip_select = 1'b1;
    spi_clk = 1'b0;
    serial_in = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock); spi_clk = 1'b1;
      repeat (3) @(negedge clock); spi_clk = 1'b0;
      repeat (3) @(negedge clock);
    end
    chk("post_rst_data", {24'b0, data_out}, 32'd0);
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_pulses", done_cnt + err_cnt, 32'd0);

    foreach (tbl[r]) begin
      d0 = done_cnt;
      e0 = err_cnt;
      cs_low();
      send_bits(tbl[r].bits, tbl[r].nbits);
      repeat (4) @(negedge clock);
      chk($sformatf("v%0d_busy_end", r), {31'b0, busy}, 32'd1);
      cs_high();
      chk($sformatf("v%0d_done_cnt", r), done_cnt - d0, tbl[r].exp_done);
      chk($sformatf("v%0d_err_cnt", r), err_cnt - e0, tbl[r].exp_err);
      chk($sformatf("v%0d_data", r), {24'b0, data_out}, {24'b0, model(tbl[r].exp_last)});
    end

    // Mid-frame reset after 4 bits: outputs clear immediately.
    cs_low();
    send_bits(16'h000A, 4);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_data", {24'b0, data_out}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chip_select = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Stray spi_clk toggles with chip_select high.
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      spi_clk = ~spi_clk;
      serial_in = $urandom_range(0, 1);
      repeat (3) @(negedge clock);
    end
    repeat (6) @(negedge clock);
    chk("stray_done", done_cnt - d0, 32'd0);
    chk("stray_err", err_cnt - e0, 32'd0);
    chk("stray_busy", {31'b0, busy}, 32'd0);
    chk("stray_data", {24'b0, data_out}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
